// File: rtl/mul_seq_ctrl_pkg.sv
// Shared definitions for the multiply sequencer: FSM state encodings and the
// default operand width.
package mul_seq_ctrl_pkg;
    localparam int DEF_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/boothmul.sv
// Combinational radix-2 Booth multiplier. It computes the full signed
// 2*DATA_WIDTH product and is meant to be timed as a multicycle path.
module boothmul #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] q_i,
    input  logic [DATA_WIDTH-1:0] m_i,
    output logic [DATA_WIDTH-1:0] hi_o,
    output logic [DATA_WIDTH-1:0] lo_o
);
    localparam int PW = 2 * DATA_WIDTH;

    logic [PW-1:0]       acc;
    logic [PW-1:0]       mext;
    logic [DATA_WIDTH:0] qx;

    always_comb begin
        mext = {{DATA_WIDTH{m_i[DATA_WIDTH-1]}}, m_i};
        qx   = {q_i, 1'b0};
        acc  = '0;
        // Recode each bit pair {q[i], q[i-1]}: 01 adds M<<i and 10 subtracts M<<i.
        for (int i = 0; i < DATA_WIDTH; i++) begin
            case (qx[i+1 -: 2])
                2'b01:   acc = acc + (mext << i);
                2'b10:   acc = acc - (mext << i);
                default: ;
            endcase
        end
    end

    assign {hi_o, lo_o} = acc;
endmodule

// File: rtl/mul_seq_ctrl.sv
// Multiply sequencer: it latches operands, holds them for MUL_LATENCY cycles across
// boothmul, and captures HI/LO. It also services mthi/mtlo. Define MUL_SEQ_PERF_EN for perf_count.
module mul_seq_ctrl
    import mul_seq_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int MUL_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] op_q,
    input  logic [DATA_WIDTH-1:0] op_m,
    input  logic                  wr_hi,
    input  logic                  wr_lo,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] HI,
    output logic [DATA_WIDTH-1:0] LO,
    output logic [31:0]           perf_count
);
    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] opq_q, opq_d, opm_q, opm_d;
    logic [DATA_WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [DATA_WIDTH-1:0] prod_hi, prod_lo;

    boothmul #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
        .q_i  (opq_q),
        .m_i  (opm_q),
        .hi_o (prod_hi),
        .lo_o (prod_lo)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opq_d   = opq_q;
        opm_d   = opm_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_EXEC;
                    cnt_d   = 4'(MUL_LATENCY - 1);
                    opq_d   = op_q;
                    opm_d   = op_m;
                end else begin
                    state_d = S_IDLE;
                    // A write made in DONE overrides the product captured one edge earlier.
                    if (wr_hi) hi_d = wr_data;
                    if (wr_lo) lo_d = wr_data;
                end
            end
            S_EXEC: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                    hi_d    = prod_hi;
                    lo_d    = prod_lo;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            opq_q   <= '0;
            opm_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opq_q   <= opq_d;
            opm_q   <= opm_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign ready = (state_q != S_EXEC);
    assign busy  = (state_q == S_EXEC);
    assign done  = (state_q == S_DONE);
    assign HI    = hi_q;
    assign LO    = lo_q;

`ifdef MUL_SEQ_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            perf_q <= '0;
        else if (state_q == S_DONE && perf_q != 32'hFFFF_FFFF)
            perf_q <= perf_q + 32'd1;
    end

    assign perf_count = perf_q;
`else
    assign perf_count = 32'd0;
`endif
endmodule
